// File: rtl/alarm_sequencer.sv
// alarm_sequencer: BCD MM:SS alarm controller (OFF/ARMED/RING/GAME) with a 60 s ring timeout and a 30 s countdown game.
// Optional: define ALARM_SNOOZE_EN to let snooze in RING push the alarm 5 minutes later and re-arm.
module alarm_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        sec_tick,
   input  logic        alarm_en,
   input  logic        set_alarm,
   input  logic [15:0] alarm_time_in,
   input  logic [15:0] current_time,
   input  logic        dismiss,
   input  logic        game_done,
   input  logic        snooze,
   output logic [2:0]  alarm_state,
   output logic [15:0] alarm_time,
   output logic [15:0] num4,
   output logic        alarm_on
);

   typedef enum logic [2:0] {
      ST_OFF   = 3'b000,
      ST_ARMED = 3'b001,
      ST_RING  = 3'b010,
      ST_GAME  = 3'b100
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] alarm_time_q, alarm_time_d;
   logic [15:0] num4_q, num4_d;
   logic [5:0]  ring_cnt_q, ring_cnt_d;
   logic        match_hist_q, match_hist_d;
   logic        alarm_on_q, alarm_on_d;
   logic        time_eq;
   logic        match;

   function automatic logic bcd_valid(input logic [15:0] t);
      return (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
             (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
   endfunction

   // MM:SS decrement with borrow rippling seconds -> tens -> minutes
   function automatic logic [15:0] bcd_dec(input logic [15:0] t);
      logic [15:0] r;
      r = t;
      if (t[3:0] != 4'd0) begin
         r[3:0] = t[3:0] - 4'd1;
      end else begin
         r[3:0] = 4'd9;
         if (t[7:4] != 4'd0) begin
            r[7:4] = t[7:4] - 4'd1;
         end else begin
            r[7:4] = 4'd5;
            if (t[11:8] != 4'd0) begin
               r[11:8] = t[11:8] - 4'd1;
            end else begin
               r[11:8]  = 4'd9;
               r[15:12] = t[15:12] - 4'd1;
            end
         end
      end
      return r;
   endfunction

`ifdef ALARM_SNOOZE_EN
   function automatic logic [15:0] bcd_add5min(input logic [15:0] t);
      logic [15:0] r;
      r = t;
      if (t[11:8] >= 4'd5) begin
         r[11:8]  = t[11:8] - 4'd5;
         r[15:12] = (t[15:12] >= 4'd5) ? 4'd0 : t[15:12] + 4'd1;
      end else begin
         r[11:8] = t[11:8] + 4'd5;
      end
      return r;
   endfunction
`else
   logic unused_snooze;
   assign unused_snooze = snooze;
`endif

   assign time_eq = (current_time == alarm_time_q);
   assign match   = sec_tick && time_eq && !match_hist_q && !set_alarm;

   // Next-state logic; alarm_en low wins over every other input
   always_comb begin
      state_d      = state_q;
      alarm_time_d = alarm_time_q;
      num4_d       = num4_q;
      ring_cnt_d   = ring_cnt_q;
      match_hist_d = match_hist_q;
      if (sec_tick) begin
         match_hist_d = time_eq;
      end
      if (!alarm_en) begin
         state_d    = ST_OFF;
         ring_cnt_d = 6'd0;
      end else begin
         case (state_q)
            ST_OFF: state_d = ST_ARMED;
            ST_ARMED: begin
               if (match) begin
                  state_d    = ST_RING;
                  ring_cnt_d = 6'd0;
               end
            end
            ST_RING: begin
               if (dismiss) begin
                  state_d = ST_GAME;
                  num4_d  = 16'h0030;
               end
`ifdef ALARM_SNOOZE_EN
               else if (snooze) begin
                  state_d      = ST_ARMED;
                  alarm_time_d = bcd_add5min(alarm_time_q);
               end
`endif
               else if (sec_tick) begin
                  if (ring_cnt_q == 6'd59) begin
                     state_d    = ST_ARMED;
                     ring_cnt_d = 6'd0;
                  end else begin
                     ring_cnt_d = ring_cnt_q + 6'd1;
                  end
               end
            end
            ST_GAME: begin
               if (game_done) begin
                  state_d = ST_ARMED;
               end else if (sec_tick) begin
                  if (num4_q == 16'h0000) begin
                     state_d    = ST_RING;
                     ring_cnt_d = 6'd0;
                  end else begin
                     num4_d = bcd_dec(num4_q);
                  end
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
      if (set_alarm && bcd_valid(alarm_time_in)) begin
         alarm_time_d = alarm_time_in;
      end
      alarm_on_d = (state_d == ST_RING);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_OFF;
         alarm_time_q <= 16'h0000;
         num4_q       <= 16'h0000;
         ring_cnt_q   <= 6'd0;
         match_hist_q <= 1'b0;
         alarm_on_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         alarm_time_q <= alarm_time_d;
         num4_q       <= num4_d;
         ring_cnt_q   <= ring_cnt_d;
         match_hist_q <= match_hist_d;
         alarm_on_q   <= alarm_on_d;
      end
   end

   assign alarm_state = state_q;
   assign alarm_time  = alarm_time_q;
   assign num4        = num4_q;
   assign alarm_on    = alarm_on_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: vector table, directed corner sequences and random stimulus
// checked against a seconds-based reference model of the alarm sequencer.
module tb_alarm_sequencer;

   logic        clk;
   logic        reset;
   logic        sec_tick, alarm_en, set_alarm, dismiss, game_done, snooze;
   logic [15:0] alarm_time_in, current_time;
   logic [2:0]  alarm_state;
   logic [15:0] alarm_time, num4;
   logic        alarm_on;

   int checks = 0;
   int fails  = 0;

   // Reference model: state code, alarm and countdown kept as plain seconds
   int m_state, m_at, m_game, m_ring;
   bit m_prev;

   typedef struct {
      bit          tick, en, set;
      logic [15:0] tin, cur;
      bit          dis, done, snz;
      logic [2:0]  st;
      logic [15:0] at, n4;
      bit          on;
   } vec_t;

   vec_t vecs[16];

   alarm_sequencer dut (
      .clk(clk), .reset(reset), .sec_tick(sec_tick), .alarm_en(alarm_en),
      .set_alarm(set_alarm), .alarm_time_in(alarm_time_in), .current_time(current_time),
      .dismiss(dismiss), .game_done(game_done), .snooze(snooze),
      .alarm_state(alarm_state), .alarm_time(alarm_time), .num4(num4), .alarm_on(alarm_on)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int to_sec(logic [15:0] b);
      return ((int'(b[15:12]) * 10 + int'(b[11:8])) * 60) + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [15:0] to_bcd(int s);
      int m, x;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   function automatic bit is_valid(logic [15:0] b);
      return (b[15:12] <= 4'd5) && (b[11:8] <= 4'd9) && (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
   endfunction

   task automatic model_reset();
      m_state = 0; m_at = 0; m_game = 0; m_ring = 0; m_prev = 0;
   endtask

   task automatic model_step(bit tick, bit en, bit set, logic [15:0] tin, logic [15:0] cur,
                             bit dis, bit done, bit snz);
      bit eq, match;
      eq    = (cur == to_bcd(m_at));
      match = tick && eq && !m_prev && !set;
      if (!en) begin
         m_state = 0;
         m_ring  = 0;
      end else begin
         case (m_state)
            0: m_state = 1;
            1: if (match) begin m_state = 2; m_ring = 0; end
            2: begin
               if (dis) begin
                  m_state = 4;
                  m_game  = 30;
               end
`ifdef ALARM_SNOOZE_EN
               else if (snz) begin
                  m_state = 1;
                  m_at    = ((m_at / 60 + 5) % 60) * 60 + m_at % 60;
               end
`endif
               else if (tick) begin
                  m_ring++;
                  if (m_ring == 60) begin m_state = 1; m_ring = 0; end
               end
            end
            4: begin
               if (done) m_state = 1;
               else if (tick) begin
                  if (m_game == 0) begin m_state = 2; m_ring = 0; end
                  else m_game--;
               end
            end
            default: m_state = 0;
         endcase
      end
      if (set && is_valid(tin)) m_at = to_sec(tin);
      if (tick) m_prev = eq;
   endtask

   task automatic check_output(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(string tag);
      check_output({tag, " state"}, 16'(alarm_state), 16'(m_state));
      check_output({tag, " alarm_time"}, alarm_time, to_bcd(m_at));
      check_output({tag, " num4"}, num4, to_bcd(m_game));
      check_output({tag, " alarm_on"}, 16'(alarm_on), 16'(m_state == 2));
   endtask

   // Drive one cycle of inputs, advance model and DUT, sample 1 ns after the edge
   task automatic apply_stimulus(bit tick, bit en, bit set, logic [15:0] tin, logic [15:0] cur,
                                 bit dis, bit done, bit snz);
      sec_tick = tick; alarm_en = en; set_alarm = set; alarm_time_in = tin;
      current_time = cur; dismiss = dis; game_done = done; snooze = snz;
      model_step(tick, en, set, tin, cur, dis, done, snz);
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(int n, logic [15:0] cur, string tag);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1, 1, 0, 16'h0, cur, 0, 0, 0);
         check_model(tag);
      end
   endtask

   task automatic trigger_ring();
      apply_stimulus(1, 1, 0, 16'h0, 16'h0000, 0, 0, 0);
      apply_stimulus(1, 1, 0, 16'h0, 16'h0105, 0, 0, 0);
      check_output("trigger ring state", 16'(alarm_state), 16'h0002);
   endtask

   initial begin
      vecs[0]  = '{0,1,0,16'h0000,16'h0000,0,0,0, 3'b001,16'h0000,16'h0000,0};
      vecs[1]  = '{0,1,1,16'h0105,16'h0000,0,0,0, 3'b001,16'h0105,16'h0000,0};
      vecs[2]  = '{0,1,1,16'h0170,16'h0000,0,0,0, 3'b001,16'h0105,16'h0000,0};
      vecs[3]  = '{1,1,0,16'h0000,16'h0104,0,0,0, 3'b001,16'h0105,16'h0000,0};
      vecs[4]  = '{1,1,0,16'h0000,16'h0105,0,0,0, 3'b010,16'h0105,16'h0000,1};
      vecs[5]  = '{1,1,0,16'h0000,16'h0105,0,0,0, 3'b010,16'h0105,16'h0000,1};
      vecs[6]  = '{0,1,0,16'h0000,16'h0105,1,0,0, 3'b100,16'h0105,16'h0030,0};
      vecs[7]  = '{1,1,0,16'h0000,16'h0105,0,0,0, 3'b100,16'h0105,16'h0029,0};
      vecs[8]  = '{0,1,0,16'h0000,16'h0105,0,1,0, 3'b001,16'h0105,16'h0029,0};
      vecs[9]  = '{1,1,0,16'h0000,16'h0105,0,0,0, 3'b001,16'h0105,16'h0029,0};
      vecs[10] = '{1,1,0,16'h0000,16'h0106,0,0,0, 3'b001,16'h0105,16'h0029,0};
      vecs[11] = '{1,1,0,16'h0000,16'h0105,0,0,0, 3'b010,16'h0105,16'h0029,1};
      vecs[12] = '{0,1,0,16'h0000,16'h0105,1,0,0, 3'b100,16'h0105,16'h0030,0};
      vecs[13] = '{0,0,0,16'h0000,16'h0105,0,0,0, 3'b000,16'h0105,16'h0030,0};
      vecs[14] = '{0,1,0,16'h0000,16'h0105,0,0,0, 3'b001,16'h0105,16'h0030,0};
      vecs[15] = '{1,1,0,16'h0000,16'h0230,1,1,0, 3'b001,16'h0105,16'h0030,0};

      reset = 1'b1;
      sec_tick = 0; alarm_en = 0; set_alarm = 0; alarm_time_in = 16'h0;
      current_time = 16'h0; dismiss = 0; game_done = 0; snooze = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_output("reset state", 16'(alarm_state), 16'h0000);
      check_output("reset alarm_time", alarm_time, 16'h0000);
      check_output("reset num4", num4, 16'h0000);
      check_output("reset alarm_on", 16'(alarm_on), 16'h0000);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i].tick, vecs[i].en, vecs[i].set, vecs[i].tin, vecs[i].cur,
                        vecs[i].dis, vecs[i].done, vecs[i].snz);
         check_output($sformatf("vec%0d state", i), 16'(alarm_state), 16'(vecs[i].st));
         check_output($sformatf("vec%0d alarm_time", i), alarm_time, vecs[i].at);
         check_output($sformatf("vec%0d num4", i), num4, vecs[i].n4);
         check_output($sformatf("vec%0d alarm_on", i), 16'(alarm_on), 16'(vecs[i].on));
      end

      // Game timeout: 30 ticks reach 00:00, the 31st returns to RING
      apply_stimulus(1, 1, 0, 16'h0, 16'h0105, 0, 0, 0);
      check_output("rearm ring state", 16'(alarm_state), 16'h0002);
      apply_stimulus(0, 1, 0, 16'h0, 16'h0105, 1, 0, 0);
      check_output("dismiss num4", num4, 16'h0030);
      tick_n(30, 16'h0105, "countdown");
      check_output("countdown end num4", num4, 16'h0000);
      apply_stimulus(1, 1, 0, 16'h0, 16'h0105, 0, 0, 0);
      check_output("game timeout state", 16'(alarm_state), 16'h0002);
      check_output("game timeout alarm_on", 16'(alarm_on), 16'h0001);

      // game_done beats a simultaneous timeout at 00:00
      apply_stimulus(0, 1, 0, 16'h0, 16'h0105, 1, 0, 0);
      tick_n(30, 16'h0105, "countdown2");
      apply_stimulus(1, 1, 0, 16'h0, 16'h0105, 0, 1, 0);
      check_output("done vs timeout state", 16'(alarm_state), 16'h0001);
      check_output("done vs timeout alarm_on", 16'(alarm_on), 16'h0000);

      // Ring timeout after 60 undismissed ticks
      trigger_ring();
      tick_n(59, 16'h0105, "ringing");
      check_output("ring 59 state", 16'(alarm_state), 16'h0002);
      apply_stimulus(1, 1, 0, 16'h0, 16'h0105, 0, 0, 0);
      check_output("ring 60 state", 16'(alarm_state), 16'h0001);
      check_output("ring 60 alarm_on", 16'(alarm_on), 16'h0000);

      // Asynchronous reset in the middle of RING
      trigger_ring();
      #2 reset = 1'b1;
      #1;
      check_output("async reset state", 16'(alarm_state), 16'h0000);
      check_output("async reset alarm_time", alarm_time, 16'h0000);
      check_output("async reset num4", num4, 16'h0000);
      check_output("async reset alarm_on", 16'(alarm_on), 16'h0000);
      #1 reset = 1'b0;
      model_reset();
      #1;
      check_output("after release state", 16'(alarm_state), 16'h0000);
      apply_stimulus(0, 0, 0, 16'h0, 16'h0105, 0, 0, 0);
      check_model("held off");
      apply_stimulus(0, 1, 0, 16'h0, 16'h0105, 0, 0, 0);
      check_model("re-enabled");

      // Snooze from 57:02
      apply_stimulus(0, 1, 1, 16'h5702, 16'h0000, 0, 0, 0);
      apply_stimulus(1, 1, 0, 16'h0, 16'h5702, 0, 0, 0);
      check_output("snooze ring state", 16'(alarm_state), 16'h0002);
      apply_stimulus(0, 1, 0, 16'h0, 16'h5702, 0, 0, 1);
`ifdef ALARM_SNOOZE_EN
      check_output("snooze state", 16'(alarm_state), 16'h0001);
      check_output("snooze alarm_time", alarm_time, 16'h0202);
`else
      check_output("snooze ignored state", 16'(alarm_state), 16'h0002);
      check_output("snooze ignored alarm_time", alarm_time, 16'h5702);
`endif
      check_model("after snooze");

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         bit          t, e, s, d, g, z;
         logic [15:0] tin, cur;
         t = ($urandom % 3) == 0;
         e = ($urandom % 40) != 0;
         s = ($urandom % 16) == 0;
         d = ($urandom % 6) == 0;
         g = ($urandom % 40) == 0;
         z = ($urandom % 10) == 0;
         tin = ($urandom % 2) ? to_bcd($urandom_range(0, 3599)) : 16'($urandom);
         case ($urandom % 4)
            0, 1: cur = to_bcd(m_at);
            2:    cur = to_bcd($urandom_range(0, 3599));
            default: cur = to_bcd((m_at + 1) % 3600);
         endcase
         apply_stimulus(t, e, s, tin, cur, d, g, z);
         check_model("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
